// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load extraction, write-back source select,
// register-file write port and retired-instruction counter.
module mem_wb_stage (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        mem_Valid,
    input  logic        mem_RegWr,
    input  logic [1:0]  mem_WbSel,
    input  logic [2:0]  mem_LoadType,
    input  logic [4:0]  mem_Rw,
    input  logic [31:0] mem_ALUout,
    input  logic [31:0] mem_Dout,
    input  logic [31:0] mem_PC8,
    output logic        WrEn,
    output logic [4:0]  Rw,
    output logic [31:0] busW,
    output logic        wb_Valid,
    output logic [31:0] retired
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [DW-1:0] load_val;
    logic [DW-1:0] wb_val;

    logic          wren_q,    wren_d;
    logic [AW-1:0] rw_q,      rw_d;
    logic [DW-1:0] busw_q,    busw_d;
    logic          valid_q,   valid_d;
    logic [DW-1:0] retired_q, retired_d;

    // Little-endian lane pick; halfword ignores address bit 0.
    always_comb begin
        byte_sel = 8'h00;
        case (mem_ALUout[1:0])
            2'd0:    byte_sel = mem_Dout[7:0];
            2'd1:    byte_sel = mem_Dout[15:8];
            2'd2:    byte_sel = mem_Dout[23:16];
            default: byte_sel = mem_Dout[31:24];
        endcase
        half_sel = mem_ALUout[1] ? mem_Dout[31:16] : mem_Dout[15:0];
    end

    // Unused load-type codes behave as lw.
    always_comb begin
        load_val = mem_Dout;
        case (mem_LoadType)
            3'b001:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b010:  load_val = {24'h000000, byte_sel};
            3'b011:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_val = {16'h0000, half_sel};
            default: load_val = mem_Dout;
        endcase
    end

    always_comb begin
        wb_val = mem_ALUout;
        case (mem_WbSel)
            2'b01:   wb_val = load_val;
            2'b10:   wb_val = mem_PC8;
            default: wb_val = mem_ALUout;
        endcase
    end

    // Flush beats Stall; the counter only moves on a normal capture.
    always_comb begin
        wren_d    = wren_q;
        rw_d      = rw_q;
        busw_d    = busw_q;
        valid_d   = valid_q;
        retired_d = retired_q;
        if (Flush) begin
            wren_d  = 1'b0;
            rw_d    = '0;
            busw_d  = '0;
            valid_d = 1'b0;
        end else if (!Stall) begin
            wren_d    = mem_Valid & mem_RegWr & (mem_Rw != AW'(0));
            rw_d      = mem_Rw;
            busw_d    = wb_val;
            valid_d   = mem_Valid;
            retired_d = retired_q + DW'(mem_Valid);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wren_q    <= 1'b0;
            rw_q      <= '0;
            busw_q    <= '0;
            valid_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            wren_q    <= wren_d;
            rw_q      <= rw_d;
            busw_q    <= busw_d;
            valid_q   <= valid_d;
            retired_q <= retired_d;
        end
    end

    assign WrEn     = wren_q;
    assign Rw       = rw_q;
    assign busW     = busw_q;
    assign wb_Valid = valid_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: driver pushes model expectations,
// monitor pops one per clock and compares all outputs.
module tb_mem_wb_stage;

    logic        Clk = 1'b0;
    logic        Rst, Stall, Flush, mem_Valid, mem_RegWr;
    logic [1:0]  mem_WbSel;
    logic [2:0]  mem_LoadType;
    logic [4:0]  mem_Rw;
    logic [31:0] mem_ALUout, mem_Dout, mem_PC8;
    logic        WrEn, wb_Valid;
    logic [4:0]  Rw;
    logic [31:0] busW, retired;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wren;
        logic [4:0]  rw;
        logic [31:0] busw;
        logic        valid;
        logic [31:0] ret;
    } exp_t;

    exp_t expq[$];
    exp_t m;

    mem_wb_stage dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
        .mem_Valid(mem_Valid), .mem_RegWr(mem_RegWr), .mem_WbSel(mem_WbSel),
        .mem_LoadType(mem_LoadType), .mem_Rw(mem_Rw), .mem_ALUout(mem_ALUout),
        .mem_Dout(mem_Dout), .mem_PC8(mem_PC8),
        .WrEn(WrEn), .Rw(Rw), .busW(busW), .wb_Valid(wb_Valid), .retired(retired)
    );

    always #5 Clk = ~Clk;

    // Reference value from plain shift/mask arithmetic.
    function automatic logic [31:0] ref_v(input logic [1:0] ws, input logic [2:0] lt,
                                          input logic [31:0] alu, input logic [31:0] dout,
                                          input logic [31:0] pc8);
        logic [31:0] b, h;
        b = (dout >> (8 * alu[1:0])) & 32'hFF;
        h = (dout >> (16 * alu[1])) & 32'hFFFF;
        if (ws == 2'b10) return pc8;
        if (ws != 2'b01) return alu;
        case (lt)
            3'd1:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return h;
            default: return dout;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit stall, input bit flush, input bit valid,
                        input bit regwr, input logic [1:0] ws, input logic [2:0] lt,
                        input logic [4:0] rw, input logic [31:0] alu, input logic [31:0] dout,
                        input logic [31:0] pc8, input bit deposit = 1'b0);
        @(negedge Clk);
        if (deposit) begin
            force dut.retired_q = 32'hFFFF_FFFF;
            #1;
            release dut.retired_q;
            m.ret = 32'hFFFF_FFFF;
        end
        Rst = rst; Stall = stall; Flush = flush; mem_Valid = valid; mem_RegWr = regwr;
        mem_WbSel = ws; mem_LoadType = lt; mem_Rw = rw;
        mem_ALUout = alu; mem_Dout = dout; mem_PC8 = pc8;
        if (rst) begin
            m.wren = 1'b0; m.rw = '0; m.busw = '0; m.valid = 1'b0; m.ret = '0;
        end else if (flush) begin
            m.wren = 1'b0; m.rw = '0; m.busw = '0; m.valid = 1'b0;
        end else if (!stall) begin
            m.valid = valid;
            m.wren  = valid && regwr && (rw != 5'd0);
            m.rw    = rw;
            m.busw  = ref_v(ws, lt, alu, dout, pc8);
            m.ret   = m.ret + (valid ? 32'd1 : 32'd0);
        end
        expq.push_back(m);
    endtask

    task automatic rnd_step(input bit rst, input bit stall, input bit flush);
        step(rst, stall, flush, 1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom),
             5'($urandom), $urandom, $urandom, $urandom);
    endtask

    // Monitor: one registered result per clock while expectations are pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("WrEn",     32'(WrEn),     32'(e.wren));
                chk("Rw",       32'(Rw),       32'(e.rw));
                chk("busW",     busW,          e.busw);
                chk("wb_Valid", 32'(wb_Valid), 32'(e.valid));
                chk("retired",  retired,       e.ret);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] D = 32'h80FF_7F01;

    initial begin
        Rst = 1'b1; Stall = 1'b0; Flush = 1'b0; mem_Valid = 1'b0; mem_RegWr = 1'b0;
        mem_WbSel = '0; mem_LoadType = '0; mem_Rw = '0;
        mem_ALUout = '0; mem_Dout = '0; mem_PC8 = '0;

        rnd_step(1, 0, 0);
        rnd_step(1, 0, 0);

        step(0, 0, 0, 1, 1, 2'b00, 3'd0, 5'd10, 32'd22, $urandom, $urandom);
        step(0, 0, 0, 1, 1, 2'b10, 3'd0, 5'd31, $urandom, $urandom, 32'h0000_0040);

        step(0, 0, 0, 1, 1, 2'b01, 3'd1, 5'd3, 32'h0000_1003, D, 0);
        step(0, 0, 0, 1, 1, 2'b01, 3'd2, 5'd4, 32'h0000_1003, D, 0);
        step(0, 0, 0, 1, 1, 2'b01, 3'd1, 5'd5, 32'h0000_1001, D, 0);
        step(0, 0, 0, 1, 1, 2'b01, 3'd3, 5'd6, 32'h0000_1002, D, 0);
        step(0, 0, 0, 1, 1, 2'b01, 3'd4, 5'd7, 32'h0000_1000, D, 0);
        step(0, 0, 0, 1, 1, 2'b01, 3'd0, 5'd8, 32'h0000_1003, D, 0);
        step(0, 0, 0, 1, 1, 2'b01, 3'd7, 5'd9, 32'h0000_1001, D, 0);
        step(0, 0, 0, 1, 1, 2'b11, 3'd1, 5'd9, 32'h1234_5678, D, 0);

        step(0, 0, 0, 1, 1, 2'b00, 3'd0, 5'd0, 32'd99, 0, 0);
        step(0, 0, 0, 0, 1, 2'b00, 3'd0, 5'd12, 32'd77, 0, 0);

        step(0, 0, 0, 1, 1, 2'b00, 3'd0, 5'd11, 32'd15, 0, 0);
        repeat (3) rnd_step(0, 1, 0);
        step(0, 1, 1, 1, 1, 2'b00, 3'd0, 5'd13, 32'd5, 0, 0);

        for (int i = 0; i < 300; i++) begin
            rnd_step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 15,
                     $urandom_range(0, 99) < 10);
        end

        step(0, 1, 0, 1, 1, 2'b00, 3'd0, 5'd1, 32'd1, 0, 0, 1'b1);
        step(0, 0, 0, 1, 1, 2'b00, 3'd0, 5'd2, 32'd2, 0, 0);
        step(0, 0, 0, 1, 1, 2'b00, 3'd0, 5'd3, 32'd3, 0, 0);
        step(1, 0, 0, 1, 1, 2'b00, 3'd0, 5'd4, 32'd4, 0, 0);
        step(0, 0, 0, 1, 1, 2'b01, 3'd1, 5'd5, 32'h0000_0002, D, 0);
        step(0, 0, 0, 0, 0, 2'b00, 3'd0, 5'd0, 0, 0, 0);

        repeat (3) @(negedge Clk);
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
